// File: rtl/bullet_pool_scheduler_if.sv
// bullet_pool_scheduler_if: launch, retire, plot handshake and status signals of the bullet slot pool
interface bullet_pool_scheduler_if #(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4
);
    logic                 frame_tick;
    logic                 fire_req;
    logic [1:0]           dir_x;
    logic [1:0]           dir_y;
    logic [7:0]           ship_x;
    logic [6:0]           ship_y;
    logic [NUM_SLOTS-1:0] retire;
    logic                 plot_ack;
    logic [NUM_SLOTS-1:0] slot_load;
    logic [1:0]           ld_dir_x;
    logic [1:0]           ld_dir_y;
    logic [7:0]           ld_x;
    logic [6:0]           ld_y;
    logic                 fire_ack;
    logic [NUM_SLOTS-1:0] slot_active;
    logic                 pool_full;
    logic [SLOT_W:0]      active_count;
    logic                 plot_req;
    logic [SLOT_W-1:0]    plot_slot;
    logic                 frame_done;
    logic                 overrun;
    logic [15:0]          shots_fired;
    logic [15:0]          fires_dropped;

    modport master (
        output frame_tick, fire_req, dir_x, dir_y, ship_x, ship_y, retire, plot_ack,
        input  slot_load, ld_dir_x, ld_dir_y, ld_x, ld_y, fire_ack, slot_active, pool_full,
               active_count, plot_req, plot_slot, frame_done, overrun, shots_fired, fires_dropped
    );

    modport slave (
        input  frame_tick, fire_req, dir_x, dir_y, ship_x, ship_y, retire, plot_ack,
        output slot_load, ld_dir_x, ld_dir_y, ld_x, ld_y, fire_ack, slot_active, pool_full,
               active_count, plot_req, plot_slot, frame_done, overrun, shots_fired, fires_dropped
    );
endinterface

// File: rtl/bullet_pool_scheduler.sv
// bullet_pool_scheduler: bullet slot allocator with frame cooldown and per-frame plot sweep
// Optional shot/drop counters are built when BULLET_SCHED_STATS_EN is defined.
module bullet_pool_scheduler #(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4,
    parameter int COOLDOWN  = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    bullet_pool_scheduler_if.slave bus
);
    localparam int CD_W = $clog2(COOLDOWN + 2);

    typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

    state_t               state;
    logic [SLOT_W-1:0]    idx;
    logic [CD_W-1:0]      cd;
    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] free_oh;
    logic [SLOT_W:0]      count;
    logic                 accept;
    logic                 last;

    always_comb begin
        free_oh = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!active[i]) free_oh = NUM_SLOTS'(1) << i;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            count = count + (SLOT_W + 1)'(active[i]);
    end

    assign accept           = bus.fire_req & ~&active & (cd == '0);
    assign last             = idx == SLOT_W'(NUM_SLOTS - 1);
    assign bus.slot_active  = active;
    assign bus.pool_full    = &active;
    assign bus.active_count = count;

    // Retires only clear bits, so a slot freed this cycle is never the allocation target.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active       <= '0;
            cd           <= '0;
            bus.slot_load <= '0;
            bus.fire_ack <= 1'b0;
            bus.ld_dir_x <= '0;
            bus.ld_dir_y <= '0;
            bus.ld_x     <= '0;
            bus.ld_y     <= '0;
        end else begin
            active        <= (active & ~bus.retire) | (accept ? free_oh : '0);
            bus.slot_load <= accept ? free_oh : '0;
            bus.fire_ack  <= accept;
            bus.ld_dir_x  <= accept ? bus.dir_x : bus.ld_dir_x;
            bus.ld_dir_y  <= accept ? bus.dir_y : bus.ld_dir_y;
            bus.ld_x      <= accept ? bus.ship_x : bus.ld_x;
            bus.ld_y      <= accept ? bus.ship_y : bus.ld_y;
            cd            <= accept ? CD_W'(COOLDOWN) : (bus.frame_tick && cd != '0) ? cd - 1'b1 : cd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            idx            <= '0;
            bus.plot_req   <= 1'b0;
            bus.plot_slot  <= '0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (bus.frame_tick && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: if (bus.frame_tick) begin
                    state <= SCAN;
                    idx   <= '0;
                end
                SCAN: if (active[idx]) begin
                    state         <= REQ;
                    bus.plot_req  <= 1'b1;
                    bus.plot_slot <= idx;
                end else if (last) begin
                    state          <= DONE;
                    bus.frame_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
                REQ: if (bus.plot_ack) begin
                    bus.plot_req   <= 1'b0;
                    state          <= last ? DONE : SCAN;
                    bus.frame_done <= last;
                    idx            <= last ? idx : idx + 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BULLET_SCHED_STATS_EN
    logic [15:0] shots;
    logic [15:0] drops;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shots <= '0;
            drops <= '0;
        end else begin
            shots <= (bus.fire_ack && shots != 16'hFFFF) ? shots + 1'b1 : shots;
            drops <= (bus.fire_req && &active && cd == '0 && drops != 16'hFFFF) ? drops + 1'b1 : drops;
        end
    end

    assign bus.shots_fired   = shots;
    assign bus.fires_dropped = drops;
`else
    assign bus.shots_fired   = '0;
    assign bus.fires_dropped = '0;
`endif
endmodule

// File: tb/tb_bullet_pool_scheduler.sv
// tb_bullet_pool_scheduler: directed checks of allocation, cooldown, retire and the plot sweep
module tb_bullet_pool_scheduler;
    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

`ifdef BULLET_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    bullet_pool_scheduler_if #(.NUM_SLOTS(16), .SLOT_W(4)) a ();
    bullet_pool_scheduler_if #(.NUM_SLOTS(16), .SLOT_W(4)) b ();

    bullet_pool_scheduler #(.NUM_SLOTS(16), .SLOT_W(4), .COOLDOWN(8)) dut_a (.clk(clk), .resetn(resetn), .bus(a));
    bullet_pool_scheduler #(.NUM_SLOTS(16), .SLOT_W(4), .COOLDOWN(0)) dut_b (.clk(clk), .resetn(resetn), .bus(b));

    typedef struct {
        logic        fire;
        logic [15:0] retire;
        logic [15:0] load;
        logic        ack;
        logic [15:0] act;
        logic [4:0]  cnt;
        logic        full;
    } vec_t;

    vec_t vt[24];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a.frame_tick = 0; a.fire_req = 0; a.dir_x = 0; a.dir_y = 0;
        a.ship_x = 0; a.ship_y = 0; a.retire = 0; a.plot_ack = 0;
        b.frame_tick = 0; b.fire_req = 0; b.dir_x = 0; b.dir_y = 0;
        b.ship_x = 0; b.ship_y = 0; b.retire = 0; b.plot_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        int          nacc;
        int          fr[3];
        logic [15:0] ldv[3];
        int          wait_n;
        int          nreq;
        int          req_cycles;
        int          ndone;
        logic [3:0]  slots[2];
        logic [3:0]  held;
        bit          stable_ok;
        bit          found;

        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        clear_inputs();

        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, 16'h0, 16'(1 << i), 1'b1, 16'((32'h1 << (i + 1)) - 1), 5'(i + 1), (i == 15)};
        vt[16] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 5'd16, 1'b1};
        vt[17] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 5'd16, 1'b1};
        vt[18] = '{1'b1, 16'h0020, 16'h0000, 1'b0, 16'hFFDF, 5'd15, 1'b0};
        vt[19] = '{1'b1, 16'h0000, 16'h0020, 1'b1, 16'hFFFF, 5'd16, 1'b1};
        vt[20] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 5'd16, 1'b1};
        vt[21] = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'hFFDF, 5'd15, 1'b0};
        vt[22] = '{1'b1, 16'h0020, 16'h0020, 1'b1, 16'hFFFF, 5'd16, 1'b1};
        vt[23] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 5'd16, 1'b1};

        // reset state
        #12;
        chk("rst_slot_load", 32'(a.slot_load), 0);
        chk("rst_fire_ack", 32'(a.fire_ack), 0);
        chk("rst_slot_active", 32'(a.slot_active), 0);
        chk("rst_pool_full", 32'(a.pool_full), 0);
        chk("rst_active_count", 32'(a.active_count), 0);
        chk("rst_plot_req", 32'(a.plot_req), 0);
        chk("rst_frame_done", 32'(a.frame_done), 0);
        chk("rst_overrun", 32'(a.overrun), 0);
        chk("rst_ld_x", 32'(a.ld_x), 0);
        chk("rst_shots", 32'(b.shots_fired), 0);
        do_reset();

        // single shot, one-cycle latency
        a.fire_req = 1; a.ship_x = 80; a.ship_y = 60; a.dir_x = 2'b01; a.dir_y = 2'b10;
        @(posedge clk); #1;
        a.fire_req = 0; a.ship_x = 5; a.ship_y = 7;
        chk("t1_slot_load", 32'(a.slot_load), 32'h1);
        chk("t1_fire_ack", 32'(a.fire_ack), 1);
        chk("t1_ld_x", 32'(a.ld_x), 80);
        chk("t1_ld_y", 32'(a.ld_y), 60);
        chk("t1_ld_dir_x", 32'(a.ld_dir_x), 1);
        chk("t1_ld_dir_y", 32'(a.ld_dir_y), 2);
        chk("t1_active_count", 32'(a.active_count), 1);
        @(posedge clk); #1;
        chk("t1_load_pulse", 32'(a.slot_load), 0);
        chk("t1_ack_pulse", 32'(a.fire_ack), 0);
        chk("t1_ld_x_hold", 32'(a.ld_x), 80);

        // cooldown of 8 frames with fire held
        do_reset();
        nacc = 0;
        a.fire_req = 1;
        for (int f = 0; f < 20; f++)
            for (int c = 0; c < 4; c++) begin
                a.frame_tick = (c == 0);
                @(posedge clk); #1;
                if (a.fire_ack) begin
                    if (nacc < 3) begin
                        fr[nacc]  = f;
                        ldv[nacc] = a.slot_load;
                    end
                    nacc++;
                end
            end
        clear_inputs();
        chk("t2_accepts", 32'(nacc), 3);
        chk("t2_frame0", 32'(fr[0]), 0);
        chk("t2_frame1", 32'(fr[1]), 8);
        chk("t2_frame2", 32'(fr[2]), 16);
        chk("t2_slot0", 32'(ldv[0]), 32'h1);
        chk("t2_slot1", 32'(ldv[1]), 32'h2);
        chk("t2_slot2", 32'(ldv[2]), 32'h4);

        // fill, full, retire and reallocate with no cooldown
        do_reset();
        for (int i = 0; i < 24; i++) begin
            b.fire_req = vt[i].fire;
            b.retire   = vt[i].retire;
            @(posedge clk); #1;
            chk($sformatf("t3_load[%0d]", i), 32'(b.slot_load), 32'(vt[i].load));
            chk($sformatf("t3_ack[%0d]", i), 32'(b.fire_ack), 32'(vt[i].ack));
            chk($sformatf("t3_active[%0d]", i), 32'(b.slot_active), 32'(vt[i].act));
            chk($sformatf("t3_count[%0d]", i), 32'(b.active_count), 32'(vt[i].cnt));
            chk($sformatf("t3_full[%0d]", i), 32'(b.pool_full), 32'(vt[i].full));
        end
        clear_inputs();
        chk("t3_fires_dropped", 32'(b.fires_dropped), STATS ? 3 : 0);
        chk("t3_shots_fired", 32'(b.shots_fired), STATS ? 18 : 0);

        // plot sweep over slots 2 and 9
        do_reset();
        b.fire_req = 1;
        repeat (10) @(posedge clk);
        #1 b.fire_req = 0;
        b.retire = 16'h01FB;
        @(posedge clk); #1;
        b.retire = 0;
        chk("t4_setup_active", 32'(b.slot_active), 32'h0204);
        b.frame_tick = 1;
        @(posedge clk); #1;
        b.frame_tick = 0;
        wait_n = 0; nreq = 0; req_cycles = 0; ndone = 0; stable_ok = 1; held = 0;
        slots[0] = 0; slots[1] = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            b.plot_ack = 0;
            if (b.plot_req) begin
                req_cycles++;
                if (wait_n == 0) begin
                    if (nreq < 2) slots[nreq] = b.plot_slot;
                    held = b.plot_slot;
                    nreq++;
                end else if (b.plot_slot != held) stable_ok = 0;
                wait_n++;
                if (wait_n == 3) b.plot_ack = 1;
            end else wait_n = 0;
            if (b.frame_done) ndone++;
        end
        chk("t4_num_req", 32'(nreq), 2);
        chk("t4_first_slot", 32'(slots[0]), 2);
        chk("t4_second_slot", 32'(slots[1]), 9);
        chk("t4_slot_stable", 32'(stable_ok), 1);
        chk("t4_req_cycles", 32'(req_cycles), 6);
        chk("t4_frame_done", 32'(ndone), 1);
        chk("t4_no_overrun", 32'(b.overrun), 0);

        // frame_tick during REQ, then async reset mid-REQ
        b.frame_tick = 1;
        @(posedge clk); #1;
        b.frame_tick = 0;
        found = 0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(posedge clk); #1;
            found = b.plot_req;
        end
        chk("t5_req_seen", 32'(found), 1);
        b.frame_tick = 1;
        @(posedge clk); #1;
        b.frame_tick = 0;
        chk("t5_overrun", 32'(b.overrun), 1);
        chk("t5_req_held", 32'(b.plot_req), 1);
        chk("t5_slot_held", 32'(b.plot_slot), 2);
        b.plot_ack = 1;
        @(posedge clk); #1;
        b.plot_ack = 0;
        chk("t5_req_dropped", 32'(b.plot_req), 0);
        found = 0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(posedge clk); #1;
            found = b.plot_req;
        end
        chk("t5_second_req", 32'(found), 1);
        chk("t5_second_slot", 32'(b.plot_slot), 9);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_req", 32'(b.plot_req), 0);
        chk("t5_async_overrun", 32'(b.overrun), 0);
        chk("t5_async_active", 32'(b.slot_active), 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // retire of inactive slots is ignored
        do_reset();
        a.fire_req = 1; a.retire = 16'h0080;
        @(posedge clk); #1;
        clear_inputs();
        chk("t6_active", 32'(a.slot_active), 32'h1);
        chk("t6_load", 32'(a.slot_load), 32'h1);
        a.retire = 16'h0008;
        @(posedge clk); #1;
        a.retire = 0;
        chk("t6_active_kept", 32'(a.slot_active), 32'h1);
        chk("t6_count", 32'(a.active_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
